// File: rtl/factorial_pkg.sv
// Shared constants and FSM encoding for the factorial accelerator.
// Register addresses, CTRL/STATUS bit positions and core state type.
package factorial_pkg;

    localparam logic [2:0] ADDR_N      = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_RESULT = 3'd3;
    localparam logic [2:0] ADDR_CYCLES = 3'd4;

    localparam int unsigned CTRL_GO     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLEAR  = 2;

    localparam int unsigned STAT_DONE   = 0;
    localparam int unsigned STAT_BUSY   = 1;
    localparam int unsigned STAT_ERR    = 2;
    localparam int unsigned STAT_GO_IGN = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/factorial_accel_if.sv
// Register bus of the factorial accelerator: write port, combinational read port and irq.
interface factorial_accel_if #(
    parameter int unsigned N_WIDTH      = 4,
    parameter int unsigned RESULT_WIDTH = 32
);
    logic                    we;
    logic [2:0]              address;
    logic [N_WIDTH-1:0]      data_in;
    logic [RESULT_WIDTH-1:0] data_out;
    logic                    irq;

    modport master (output we, output address, output data_in, input data_out, input irq);
    modport slave  (input we, input address, input data_in, output data_out, output irq);
endinterface

// File: rtl/factorial_core.sv
// Iterative factorial engine: one truncated multiply per clock, overflow flag per step,
// and a count of CALC cycles for the current run.
module factorial_core
    import factorial_pkg::*;
#(
    parameter int unsigned N_WIDTH      = 4,
    parameter int unsigned RESULT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [N_WIDTH-1:0]      n,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [RESULT_WIDTH-1:0] product,
    output logic                    ovf,
    output logic [RESULT_WIDTH-1:0] cycles
);

    localparam int unsigned FullWidth = RESULT_WIDTH + N_WIDTH;

    fsm_state_e              state_q, state_d;
    logic [N_WIDTH-1:0]      cnt_q, cnt_d;
    logic [RESULT_WIDTH-1:0] product_q, product_d;
    logic [RESULT_WIDTH-1:0] cycles_q, cycles_d;
    logic [FullWidth-1:0]    mul_a, mul_b, prod_full;

    assign mul_a     = {{N_WIDTH{1'b0}}, product_q};
    assign mul_b     = {{RESULT_WIDTH{1'b0}}, cnt_q};
    assign prod_full = mul_a * mul_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            product_q <= '0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        cycles_d   = cycles_q;
        done_pulse = 1'b0;
        ovf        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // The DONE cycle accepts a new start so runs can go back to back.
                if (start) begin
                    state_d   = CALC;
                    cnt_d     = n;
                    product_d = RESULT_WIDTH'(1);
                    cycles_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                cycles_d = cycles_q + RESULT_WIDTH'(1);
                if (cnt_q <= N_WIDTH'(1)) begin
                    state_d    = DONE;
                    done_pulse = 1'b1;
                end else begin
                    product_d = prod_full[RESULT_WIDTH-1:0];
                    cnt_d     = cnt_q - N_WIDTH'(1);
                    ovf       = |prod_full[FullWidth-1:RESULT_WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == CALC);
    assign product = product_q;
    assign cycles  = cycles_q;

endmodule

// File: rtl/factorial_accel.sv
// Register-mapped factorial accelerator: register file, status flags, read mux and irq
// around the iterative core.
module factorial_accel
    import factorial_pkg::*;
#(
    parameter int unsigned N_WIDTH      = 4,
    parameter int unsigned RESULT_WIDTH = 32
) (
    input logic             clk,
    input logic             reset_n,
    factorial_accel_if.slave bus
);

    logic [N_WIDTH-1:0]      n_q, n_d;
    logic                    irq_en_q, irq_en_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    go_ign_q, go_ign_d;
    logic                    ctrl_wr, go_req, clear_req, go_acc;
    logic                    busy, done_pulse, ovf;
    logic [RESULT_WIDTH-1:0] product, cycles;

    assign ctrl_wr   = bus.we && (bus.address == ADDR_CTRL);
    assign go_req    = ctrl_wr && bus.data_in[CTRL_GO];
    assign clear_req = ctrl_wr && bus.data_in[CTRL_CLEAR];
    assign go_acc    = go_req && !busy;

    factorial_core #(
        .N_WIDTH     (N_WIDTH),
        .RESULT_WIDTH(RESULT_WIDTH)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (go_acc),
        .n         (n_q),
        .busy      (busy),
        .done_pulse(done_pulse),
        .product   (product),
        .ovf       (ovf),
        .cycles    (cycles)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q      <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            go_ign_q <= 1'b0;
        end else begin
            n_q      <= n_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            go_ign_q <= go_ign_d;
        end
    end

    always_comb begin
        n_d      = n_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        go_ign_d = go_ign_q;
        if (bus.we && (bus.address == ADDR_N)) n_d = bus.data_in;
        if (ctrl_wr) irq_en_d = bus.data_in[CTRL_IRQ_EN];
        // An accepted go clears every flag, so it takes priority over clear.
        if (go_acc) begin
            done_d   = 1'b0;
            err_d    = 1'b0;
            go_ign_d = 1'b0;
        end else begin
            if (done_pulse) done_d = 1'b1;
            else if (clear_req) done_d = 1'b0;
            if (clear_req) err_d = 1'b0;
            if (ovf) err_d = 1'b1;
            if (go_req) go_ign_d = 1'b1;
            else if (clear_req) go_ign_d = 1'b0;
        end
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            ADDR_N: bus.data_out[N_WIDTH-1:0] = n_q;
            ADDR_STATUS: begin
                bus.data_out[STAT_DONE]   = done_q;
                bus.data_out[STAT_BUSY]   = busy;
                bus.data_out[STAT_ERR]    = err_q;
                bus.data_out[STAT_GO_IGN] = go_ign_q;
            end
            ADDR_RESULT: bus.data_out = product;
            ADDR_CYCLES: bus.data_out = cycles;
            default:     bus.data_out = '0;
        endcase
    end

    assign bus.irq = done_q & irq_en_q;

endmodule

// File: tb/tb_factorial_accel.sv
// Self-checking bench for factorial_accel: a default-width and a 5/64-bit instance
// checked against an exact-arithmetic factorial model.
module tb_factorial_accel;
    import factorial_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    factorial_accel_if #(.N_WIDTH(4), .RESULT_WIDTH(32)) bus_a ();
    factorial_accel_if #(.N_WIDTH(5), .RESULT_WIDTH(64)) bus_b ();

    factorial_accel #(.N_WIDTH(4), .RESULT_WIDTH(32)) dut_a (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_a)
    );

    factorial_accel #(.N_WIDTH(5), .RESULT_WIDTH(64)) dut_b (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_b)
    );

    function automatic logic [127:0] fact(input int n);
        logic [127:0] f;
        f = 128'd1;
        for (int i = 2; i <= n; i++) f = f * 128'(i);
        return f;
    endfunction

    function automatic int max1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    task automatic wr(input bit sel, input logic [2:0] a, input logic [7:0] d);
        if (sel) begin
            bus_b.we = 1'b1; bus_b.address = a; bus_b.data_in = d[4:0];
        end else begin
            bus_a.we = 1'b1; bus_a.address = a; bus_a.data_in = d[3:0];
        end
        @(posedge clk);
        #1;
        bus_a.we = 1'b0;
        bus_b.we = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, output logic [63:0] v);
        if (sel) begin
            bus_b.address = a; #1; v = bus_b.data_out;
        end else begin
            bus_a.address = a; #1; v = 64'(bus_a.data_out);
        end
    endtask

    // Counts edges after the go edge until done reads 1; -1 if the budget runs out.
    task automatic poll_done(input bit sel, output int edges);
        logic [63:0] s;
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            rd(sel, ADDR_STATUS, s);
            if (s[0]) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_one_run(input bit sel, input int n);
        logic [127:0] f;
        logic [63:0]  exp_res, v;
        logic         exp_err;
        int           edges;
        f = fact(n);
        if (sel) begin
            exp_res = f[63:0]; exp_err = |f[127:64];
        end else begin
            exp_res = 64'(f[31:0]); exp_err = |f[127:32];
        end
        wr(sel, ADDR_N, 8'(n));
        wr(sel, ADDR_CTRL, 8'd1);
        poll_done(sel, edges);
        checks++;
        if (edges !== max1(n)) begin
            errors++;
            $display("FAIL done_latency sel=%0d n=%0d: got %0d expected %0d", sel, n, edges, max1(n));
        end
        rd(sel, ADDR_RESULT, v);
        checks++;
        if (v !== exp_res) begin
            errors++;
            $display("FAIL result sel=%0d n=%0d: got %0d expected %0d", sel, n, v, exp_res);
        end
        rd(sel, ADDR_CYCLES, v);
        checks++;
        if (v !== 64'(max1(n))) begin
            errors++;
            $display("FAIL cycles sel=%0d n=%0d: got %0d expected %0d", sel, n, v, max1(n));
        end
        rd(sel, ADDR_STATUS, v);
        checks++;
        if (v[3:0] !== {1'b0, exp_err, 2'b01}) begin
            errors++;
            $display("FAIL status sel=%0d n=%0d: got %b expected %b", sel, n, v[3:0],
                     {1'b0, exp_err, 2'b01});
        end
    endtask

    task automatic test_reset();
        logic [63:0] v;
        reset_n = 1'b0;
        #3;
        for (int a = 0; a < 8; a++) begin
            rd(0, 3'(a), v);
            checks++;
            if (v !== 64'd0) begin
                errors++; $display("FAIL reset_read_a addr=%0d: got %0d expected 0", a, v);
            end
            rd(1, 3'(a), v);
            checks++;
            if (v !== 64'd0) begin
                errors++; $display("FAIL reset_read_b addr=%0d: got %0d expected 0", a, v);
            end
        end
        checks++;
        if ({bus_a.irq, bus_b.irq} !== 2'b00) begin
            errors++; $display("FAIL reset_irq: got %b expected 00", {bus_a.irq, bus_b.irq});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        for (int n = 0; n <= 13; n++) test_one_run(0, n);
    endtask

    task automatic test_busy_writes();
        logic [63:0] v;
        int          edges;
        wr(0, ADDR_N, 8'd8);
        wr(0, ADDR_CTRL, 8'd1);
        @(posedge clk);
        #1;
        wr(0, ADDR_N, 8'd3);
        wr(0, ADDR_CTRL, 8'd1);
        poll_done(0, edges);
        checks++;
        if (edges !== 5) begin
            errors++; $display("FAIL busy_latency: got %0d expected 5", edges);
        end
        rd(0, ADDR_RESULT, v);
        checks++;
        if (v !== 64'(fact(8))) begin
            errors++; $display("FAIL busy_result: got %0d expected %0d", v, fact(8));
        end
        rd(0, ADDR_STATUS, v);
        checks++;
        if (v[3:0] !== 4'b1001) begin
            errors++; $display("FAIL busy_go_ign: got %b expected 1001", v[3:0]);
        end
        rd(0, ADDR_N, v);
        checks++;
        if (v !== 64'd3) begin
            errors++; $display("FAIL busy_n_reg: got %0d expected 3", v);
        end
        wr(0, ADDR_CTRL, 8'd1);
        poll_done(0, edges);
        rd(0, ADDR_RESULT, v);
        checks++;
        if (v !== 64'd6 || edges !== 3) begin
            errors++; $display("FAIL rerun_n3: got %0d after %0d edges expected 6 after 3", v, edges);
        end
        rd(0, ADDR_STATUS, v);
        checks++;
        if (v[3] !== 1'b0) begin
            errors++; $display("FAIL rerun_go_ign: got %b expected 0", v[3]);
        end
    endtask

    task automatic test_irq();
        logic [63:0] s, v;
        int          edges;
        wr(0, ADDR_CTRL, 8'd6);
        checks++;
        if (bus_a.irq !== 1'b0) begin
            errors++; $display("FAIL irq_after_clear: got %b expected 0", bus_a.irq);
        end
        wr(0, ADDR_N, 8'd4);
        wr(0, ADDR_CTRL, 8'd3);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            rd(0, ADDR_STATUS, s);
            checks++;
            if (bus_a.irq !== s[0]) begin
                errors++; $display("FAIL irq_track k=%0d: got %b expected %b", k, bus_a.irq, s[0]);
            end
            if (s[0]) begin
                edges = k;
                break;
            end
        end
        rd(0, ADDR_RESULT, v);
        checks++;
        if (v !== 64'd24 || edges !== 4 || bus_a.irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_run: got result %0d edges %0d irq %b expected 24 4 1", v, edges,
                     bus_a.irq);
        end
        wr(0, ADDR_CTRL, 8'd4);
        rd(0, ADDR_STATUS, s);
        checks++;
        if ({bus_a.irq, s[0]} !== 2'b00) begin
            errors++; $display("FAIL irq_clear: got %b expected 00", {bus_a.irq, s[0]});
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        int          edges;
        test_one_run(0, 5);
        // Still in the DONE cycle here, so this go must be accepted.
        wr(0, ADDR_CTRL, 8'd1);
        poll_done(0, edges);
        checks++;
        if (edges !== 5) begin
            errors++; $display("FAIL b2b_latency: got %0d expected 5", edges);
        end
        rd(0, ADDR_STATUS, v);
        checks++;
        if (v[3:0] !== 4'b0001) begin
            errors++; $display("FAIL b2b_status: got %b expected 0001", v[3:0]);
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] v;
        wr(0, ADDR_CTRL, 8'd2);
        wr(0, ADDR_N, 8'd10);
        wr(0, ADDR_CTRL, 8'd3);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
        for (int a = 0; a < 8; a++) begin
            rd(0, 3'(a), v);
            checks++;
            if (v !== 64'd0) begin
                errors++; $display("FAIL midreset_read addr=%0d: got %0d expected 0", a, v);
            end
        end
        checks++;
        if (bus_a.irq !== 1'b0) begin
            errors++; $display("FAIL midreset_irq: got %b expected 0", bus_a.irq);
        end
        @(posedge clk);
        #1;
        test_one_run(0, 3);
    endtask

    task automatic test_wide();
        test_one_run(1, 20);
        test_one_run(1, 21);
    endtask

    task automatic test_random();
        repeat (6) test_one_run(0, int'($urandom_range(0, 15)));
        repeat (4) test_one_run(1, int'($urandom_range(0, 31)));
    endtask

    initial begin
        bus_a.we = 1'b0; bus_a.address = 3'd0; bus_a.data_in = '0;
        bus_b.we = 1'b0; bus_b.address = 3'd0; bus_b.data_in = '0;
        test_reset();
        test_sweep();
        test_busy_writes();
        test_irq();
        test_back_to_back();
        test_mid_reset();
        test_wide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/factorial_accel.md
# factorial_accel

Parametrised, register-mapped iterative factorial accelerator; successor to the fixed 4-bit/32-bit factorial wrapper. A host writes n and a go command over a small address/write-enable bus. The block computes n! one multiplication per clock and reports the result through the same bus. It adds configurable widths, overflow detection, busy/ignored-go status, a run-cycle counter and a maskable completion interrupt. It sits on the lab's simple processor bus beside the other memory-mapped peripherals.

## Interface
- N_WIDTH, default 4: width of n and of data_in. Must be ≥ 3.
- RESULT_WIDTH, default 32: width of the result register and of data_out. Must be ≥ 8.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  write enable, sampled at rising clk
- address  in  3  register select
- data_in  in  N_WIDTH  write data
- data_out  out  RESULT_WIDTH  read data, combinational from address, zero-extended
- irq  out  1  done & irq_en

## Operation
- Address map:
  - 0 N: n_reg, read/write.
  - 1 CTRL: write-only; reads return 0.
    - bit0 go, self-clearing.
    - bit1 irq_en, stored.
    - bit2 clear, self-clearing; clears done, err and go_ign.
  - 2 STATUS, read-only:
    - bit0 done.
    - bit1 busy.
    - bit2 err (overflow in last run).
    - bit3 go_ign.
  - 3 RESULT, read-only.
  - 4 CYCLES, read-only: CALC cycles spent in last run.
  - 5–7: read 0; writes ignored.
- FSM states and transitions:
  - IDLE → CALC on an accepted go. Same edge loads cnt←n_reg, product←1, cycles←0, and clears done, err, go_ign.
  - CALC, each edge: cycles+1.
    - If cnt ≤ 1 → DONE.
    - Otherwise product←product×cnt and cnt←cnt−1.
  - DONE → IDLE on the next edge. done is set on entry to DONE.
- The wrapper writes product to RESULT continuously.
- busy = (state == CALC).
- Arithmetic: the multiply is formed at full width, RESULT_WIDTH+N_WIDTH.
  - If any bit above RESULT_WIDTH−1 is non-zero, err is set. err stays set to the end of the run.
  - product keeps the truncated low RESULT_WIDTH bits.
  - The computation continues to completion.
- A go while busy is ignored and sets go_ign. The running computation is unaffected.
- A write to N while busy updates n_reg only. The running cnt is unaffected.
- If go and clear are in the same CTRL write while idle, go wins: flags are cleared and the run starts.
- A clear while busy clears err and go_ign only.
- done stays set until the next accepted go or a clear.
- reset_n low, asynchronously and at any time, including mid-run:
  - state IDLE.
  - n_reg, result, cycles and cnt all 0.
  - done, err, go_ign and irq_en all 0.
  - Outputs after reset: irq 0; data_out 0 for every address.

## Timing
- The go write edge is edge 0. done reads 1 after edge max(n,1).
- CYCLES = max(n,1).
- Examples:
  - n=0 or n=1: done after edge 1, result 1.
  - n=5: done after edge 5.
- busy is 1 from after edge 0 until after edge max(n,1).
- irq follows done & irq_en combinationally; no extra latency.
- Register writes take effect at the write edge. Reads are valid in the same cycle that address is driven.
- Back-to-back: a go is accepted in the cycle the state is DONE or IDLE, i.e. at the earliest one edge after done is set.

## Structure
- Package factorial_pkg holds:
  - Address constants: ADDR_N, ADDR_CTRL, ADDR_STATUS, ADDR_RESULT, ADDR_CYCLES.
  - CTRL and STATUS bit indices.
  - FSM state encoding: IDLE, CALC, DONE.
- Sub-module factorial_core holds the FSM, cnt, product, overflow detect and cycle counter. It has ports start, n, busy, done_pulse, product, ovf and cycles.
- The top level holds the register file, flag logic, read mux and irq.

## Test plan
- Defaults; for n = 0..12, write N, then CTRL=1, poll STATUS.
  - done after max(n,1) edges.
  - RESULT equals n!, for example 10! = 3628800 and 12! = 479001600.
  - CYCLES = max(n,1); err = 0.
- n=13 → done after 13 edges, err=1, RESULT = 6227020800 mod 2^32 = 1932053504.
- During an n=8 run:
  - Write N=3 at edge 2 and go at edge 3.
  - Required: result 40320, go_ign=1, n_reg reads 3.
  - A following go computes 6.
- CTRL=0b010 (irq_en), then an n=4 run: irq rises with done, result 24. A CTRL clear (0b100) drops irq and done to 0.
- Assert reset_n low for 1 ns mid n=10 run (edge 4):
  - All registers read 0, irq 0, state idle.
  - A fresh n=3 run gives 6 after 3 edges.
- Widths N_WIDTH=5, RESULT_WIDTH=64: n=20 gives 2432902008176640000 with err=0; n=21 sets err=1.
